// File: rtl/mem_arbiter.sv
// Shared main-memory port arbiter for an I-cache and a D-cache.
// Block fills are pipelined reads of WORDS 16-bit words; D writes are single-word write-through.
module mem_arbiter #(
  parameter int unsigned WORDS = 8
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       i_req,
  input  logic [15:0]                i_addr,
  input  logic                       d_req,
  input  logic                       d_write,
  input  logic [15:0]                d_addr,
  input  logic [15:0]                d_wdata,
  output logic [15:0]                i_data,
  output logic                       i_valid,
  output logic [$clog2(WORDS)-1:0]   i_word,
  output logic                       i_done,
  output logic [15:0]                d_data,
  output logic                       d_valid,
  output logic [$clog2(WORDS)-1:0]   d_word,
  output logic                       d_done,
  output logic                       mem_en,
  output logic                       mem_wr,
  output logic [15:0]                mem_addr,
  output logic [15:0]                mem_wdata,
  input  logic [15:0]                mem_rdata,
  input  logic                       mem_rvalid
);

  localparam int unsigned CW      = $clog2(WORDS);
  localparam logic [CW:0] WORDS_C = (CW+1)'(WORDS);
  localparam logic [CW:0] LAST_C  = (CW+1)'(WORDS - 1);
  localparam logic [CW:0] ONE_C   = (CW+1)'(1);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_IFILL  = 2'd1,
    ST_DFILL  = 2'd2,
    ST_DWRITE = 2'd3
  } state_e;

  state_e      state_q, state_d;
  logic [CW:0] issue_cnt_q, issue_cnt_d;
  logic [CW:0] return_cnt_q, return_cnt_d;
  logic        last_d_q, last_d_d;
  logic [15:0] addr_q, addr_d;
  logic [15:0] wdata_q, wdata_d;

  logic in_fill;
  logic issuing;
  logic fill_ret;
  logic last_ret;
  logic pick_d;
  logic pick_i;

  assign in_fill  = (state_q == ST_IFILL) || (state_q == ST_DFILL);
  assign issuing  = in_fill && (issue_cnt_q < WORDS_C);
  assign fill_ret = in_fill && mem_rvalid;
  assign last_ret = fill_ret && (return_cnt_q == LAST_C);
  // Under contention D wins unless it was the most recent grant.
  assign pick_d   = d_req && (!i_req || !last_d_q);
  assign pick_i   = i_req && !pick_d;

  // Next-state, counter and capture-register logic.
  always_comb begin
    state_d      = state_q;
    issue_cnt_d  = issue_cnt_q;
    return_cnt_d = return_cnt_q;
    last_d_d     = last_d_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    case (state_q)
      ST_IDLE: begin
        issue_cnt_d  = '0;
        return_cnt_d = '0;
        if (pick_d) begin
          last_d_d = 1'b1;
          addr_d   = d_addr;
          wdata_d  = d_wdata;
          if (d_write) begin
            state_d = ST_DWRITE;
          end else begin
            state_d = ST_DFILL;
          end
        end else if (pick_i) begin
          last_d_d = 1'b0;
          addr_d   = i_addr;
          state_d  = ST_IFILL;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_IFILL, ST_DFILL: begin
        if (issuing) begin
          issue_cnt_d = issue_cnt_q + ONE_C;
        end else begin
          issue_cnt_d = issue_cnt_q;
        end
        if (last_ret) begin
          state_d      = ST_IDLE;
          issue_cnt_d  = '0;
          return_cnt_d = '0;
        end else if (fill_ret) begin
          return_cnt_d = return_cnt_q + ONE_C;
        end else begin
          return_cnt_d = return_cnt_q;
        end
      end
      ST_DWRITE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      issue_cnt_q  <= '0;
      return_cnt_q <= '0;
      last_d_q     <= 1'b0;
      addr_q       <= 16'h0000;
      wdata_q      <= 16'h0000;
    end else begin
      state_q      <= state_d;
      issue_cnt_q  <= issue_cnt_d;
      return_cnt_q <= return_cnt_d;
      last_d_q     <= last_d_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
    end
  end

  // Output decode; returned data is a same-cycle passthrough of mem_rdata.
  always_comb begin
    i_data    = 16'h0000;
    i_valid   = 1'b0;
    i_word    = '0;
    i_done    = 1'b0;
    d_data    = 16'h0000;
    d_valid   = 1'b0;
    d_word    = '0;
    d_done    = 1'b0;
    mem_en    = 1'b0;
    mem_wr    = 1'b0;
    mem_addr  = 16'h0000;
    mem_wdata = 16'h0000;
    if (issuing) begin
      mem_en   = 1'b1;
      mem_addr = {addr_q[15:CW+1], issue_cnt_q[CW-1:0], 1'b0};
    end else begin
      mem_en   = 1'b0;
    end
    case (state_q)
      ST_IFILL: begin
        if (fill_ret) begin
          i_valid = 1'b1;
          i_data  = mem_rdata;
          i_word  = return_cnt_q[CW-1:0];
          i_done  = last_ret;
        end else begin
          i_valid = 1'b0;
        end
      end
      ST_DFILL: begin
        if (fill_ret) begin
          d_valid = 1'b1;
          d_data  = mem_rdata;
          d_word  = return_cnt_q[CW-1:0];
          d_done  = last_ret;
        end else begin
          d_valid = 1'b0;
        end
      end
      ST_DWRITE: begin
        mem_en    = 1'b1;
        mem_wr    = 1'b1;
        mem_addr  = addr_q & 16'hFFFE;
        mem_wdata = wdata_q;
        d_done    = 1'b1;
      end
      default: begin
        mem_wr = 1'b0;
      end
    endcase
  end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter: WORDS, 8, words per cache block (power of 2, >= 2); block = WORDS x 16-bit words, byte-addressed.
REQ-002 clk  in  1  clock; all state changes on rising edge.
REQ-003 rst  in  1  synchronous, active-high reset.
REQ-004 i_req  in  1  I-cache miss request; held high until i_done.
REQ-005 i_addr  in  16  I-cache miss address (any byte within block).
REQ-006 d_req  in  1  D-cache request; held high until d_done.
REQ-007 d_write  in  1  1 = single-word write-through, 0 = block fill.
REQ-008 d_addr  in  16  D-cache address.
REQ-009 d_wdata  in  16  D-cache write data.
REQ-010 i_data, d_data  out  16  returned fill word (mem_rdata passthrough).
REQ-011 i_valid, d_valid  out  1  fill word valid this cycle.
REQ-012 i_word, d_word  out  log2(WORDS)  word index of the valid fill word.
REQ-013 i_done, d_done  out  1  one-cycle completion pulse.
REQ-014 mem_en, mem_wr  out  1  main-memory enable, write strobe.
REQ-015 mem_addr, mem_wdata  out  16  main-memory address, write data.
REQ-016 mem_rdata  in  16;  mem_rvalid  in  1  read data and its valid, fixed latency after issue.

Function
REQ-017 States: IDLE, IFILL, DFILL, DWRITE; exactly one active.
REQ-018 IDLE, only d_req: next DWRITE if d_write else DFILL; only i_req: next IFILL; none: stay.
REQ-019 IDLE, both: grant the requester not granted last (last_d flag); last_d resets to 0, so D wins first contention.
REQ-020 Address (and d_wdata) latched on the grant edge; later input changes ignored until done.
REQ-021 Fill issue: first WORDS cycles in IFILL/DFILL, mem_en=1, mem_wr=0, mem_addr = {latched_addr[15:log2(WORDS)+1], issue_cnt, 1'b0}, issue_cnt 0..WORDS-1 ascending.
REQ-022 Each mem_rvalid during a fill: owner x_valid=1, x_data=mem_rdata, x_word=return_cnt, return_cnt++; other requester's valid stays 0.
REQ-023 Cycle of WORDS-th return: x_done=1, state -> IDLE; next grant evaluated the following cycle.
REQ-024 After issue phase, mem_en=0 until fill ends; no new requests issued while returns outstanding.
REQ-025 DWRITE: one cycle, mem_en=1, mem_wr=1, mem_addr = latched d_addr with bit0 cleared, mem_wdata = latched d_wdata, d_done=1; -> IDLE.
REQ-026 mem_rvalid in IDLE/DWRITE or beyond WORDS returns: ignored, no valid/done.
REQ-027 Requester deasserting req mid-operation: operation still completes; done still pulses.
REQ-028 In IDLE all outputs 0; mem_addr/mem_wdata 0 when mem_en=0.
REQ-029 Grant latency 1 cycle: req seen at edge N, first mem_en cycle N+1; with memory latency L, done = grant + WORDS-1 + L cycles.

Reset
REQ-030 rst=1 at an edge: state IDLE, issue_cnt=0, return_cnt=0, last_d=0, latched regs 0, all outputs 0.
REQ-031 Reset mid-fill aborts; no done; rvalids arriving after reset ignored per REQ-026.
REQ-032 rst dominates req in the same cycle; grant earliest the cycle after rst deasserts.

Verification
REQ-033 i_req, i_addr=0x1236, L=4 -> mem_addr 0x1230,0x1232..0x123E on 8 consecutive cycles; i_word 0..7 returned; i_done on 8th return, 11 cycles after first issue... i.e. cycle grant+11.
REQ-034 d_req,d_write=1, d_addr=0x0043, d_wdata=0xBEEF -> one cycle mem_en=1,mem_wr=1,mem_addr=0x0042,mem_wdata=0xBEEF,d_done=1.
REQ-035 i_req and d_req (fill) same cycle after reset -> D filled first, then I granted cycle after d_done; repeated contention alternates.
REQ-036 rst asserted at 3rd return of a D fill -> outputs 0 next cycle; remaining rvalids produce no d_valid/d_done.
REQ-037 Spurious mem_rvalid in IDLE, and d_addr changed mid-fill -> no valid/done; issued addresses use latched value.
